// File: rtl/gmsk_tx_pkg.sv
// gmsk_tx_pkg: shared state encoding, default burst geometry and small
// helpers for the GMSK transmit sequencer.
package gmsk_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEAD    = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_TAIL    = 3'd3,
      ST_GUARD   = 3'd4
   } tx_state_t;

   localparam int DEF_TAIL_BITS          = 3;
   localparam int DEF_BURST_BITS         = 142;
   localparam int DEF_GUARD_SYMBOLS      = 8;
   localparam int DEF_SAMPLES_PER_SYMBOL = 128;

   // Largest of three counts, used to size the shared per-state symbol counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Fixed burst order; GUARD wraps back to IDLE.
   function automatic tx_state_t next_phase(input tx_state_t s);
      tx_state_t n;
      case (s)
         ST_HEAD:    n = ST_PAYLOAD;
         ST_PAYLOAD: n = ST_TAIL;
         ST_TAIL:    n = ST_GUARD;
         default:    n = ST_IDLE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/gmsk_strobe_gen.sv
// gmsk_strobe_gen: clock divider and sample counter producing the
// modulator's sample strobe, symbol strobe and end-of-symbol tick.
// A synchronous clear parks both counters at zero.
module gmsk_strobe_gen #(
   parameter int CLOCKS_PER_SAMPLE  = 4,
   parameter int SAMPLES_PER_SYMBOL = 128
) (
   input  logic clock,
   input  logic clear,
   input  logic enable,
   output logic sample_strobe,
   output logic symbol_strobe,
   output logic symbol_end
);

   localparam int DIV_W = (CLOCKS_PER_SAMPLE > 1) ? $clog2(CLOCKS_PER_SAMPLE) : 1;
   localparam int CNT_W = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCKS_PER_SAMPLE - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYMBOL - 1);

   logic [DIV_W-1:0] clk_div;
   logic [CNT_W-1:0] sample_cnt;

   // Divide the system clock into samples, then count samples into symbols.
   always_ff @(posedge clock) begin
      if (clear) begin
         clk_div    <= '0;
         sample_cnt <= '0;
      end else if (enable) begin
         if (clk_div == DIV_LAST) begin
            clk_div    <= '0;
            sample_cnt <= (sample_cnt == CNT_LAST) ? '0 : sample_cnt + 1'b1;
         end else begin
            clk_div <= clk_div + 1'b1;
         end
      end
   end

   assign sample_strobe = enable && (clk_div == DIV_LAST);
   assign symbol_strobe = enable && (clk_div == '0) && (sample_cnt == '0);
   assign symbol_end    = sample_strobe && (sample_cnt == CNT_LAST);

endmodule

// File: rtl/gmsk_tx_sequencer.sv
// gmsk_tx_sequencer: burst controller for gmsk_tx. Frames each burst as
// head tail, payload pulled through a valid/ready handshake, trailing tail
// and guard, and generates the modulator strobes.
// Optional build macro GMSK_TX_DIFF_ENCODE_EN: differentially encode payload
// bits (previous encoded bit seeded to 1 at burst start).
module gmsk_tx_sequencer
   import gmsk_tx_pkg::*;
#(
   parameter int CLOCKS_PER_SAMPLE  = 4,
   parameter int SAMPLES_PER_SYMBOL = DEF_SAMPLES_PER_SYMBOL,
   parameter int BURST_BITS         = DEF_BURST_BITS,
   parameter int TAIL_BITS          = DEF_TAIL_BITS,
   parameter int GUARD_SYMBOLS      = DEF_GUARD_SYMBOLS
) (
   input  logic clock,
   input  logic reset,
   input  logic burst_start,
   input  logic bit_valid,
   input  logic bit_data,
   output logic bit_ready,
   output logic mod_symbol_strobe,
   output logic mod_sample_strobe,
   output logic mod_input_bit,
   output logic mod_clk_en,
   output logic tx_active,
   output logic burst_done,
   output logic underrun
);

   localparam int SYM_MAX = max3(TAIL_BITS, BURST_BITS, GUARD_SYMBOLS);
   localparam int SYM_W   = (SYM_MAX > 1) ? $clog2(SYM_MAX) : 1;
   localparam logic [SYM_W-1:0] TAIL_LAST  = SYM_W'(TAIL_BITS - 1);
   localparam logic [SYM_W-1:0] PAY_LAST   = SYM_W'(BURST_BITS - 1);
   localparam logic [SYM_W-1:0] GUARD_LAST = SYM_W'(GUARD_SYMBOLS - 1);

   tx_state_t        state, state_n;
   logic [SYM_W-1:0] sym_cnt, sym_cnt_n;
   logic             bit_q, bit_n;
   logic             underrun_q, underrun_n;
   logic             done_q, done_n;
   logic             sym_last, enc_bit;
   logic             running, accept;
   logic             sample_strobe, symbol_strobe, symbol_end;
`ifdef GMSK_TX_DIFF_ENCODE_EN
   logic             prev_q, prev_n;
`endif

   assign running = (state != ST_IDLE);
   // The done cycle itself must not start a burst, hence the done_q gate.
   assign accept  = (state == ST_IDLE) && burst_start && !done_q;

   gmsk_strobe_gen #(
      .CLOCKS_PER_SAMPLE (CLOCKS_PER_SAMPLE),
      .SAMPLES_PER_SYMBOL(SAMPLES_PER_SYMBOL)
   ) strobe_gen (
      .clock        (clock),
      .clear        (reset || !running),
      .enable       (running),
      .sample_strobe(sample_strobe),
      .symbol_strobe(symbol_strobe),
      .symbol_end   (symbol_end)
   );

   // Next-state, symbol counting, symbol bit selection and sticky underrun.
   always_comb begin
      state_n    = state;
      sym_cnt_n  = sym_cnt;
      bit_n      = bit_q;
      underrun_n = underrun_q;
      done_n     = 1'b0;
      sym_last   = 1'b0;
`ifdef GMSK_TX_DIFF_ENCODE_EN
      prev_n     = prev_q;
      enc_bit    = (bit_valid & bit_data) ^ prev_q;
`else
      enc_bit    = bit_valid & bit_data;
`endif
      case (state)
         ST_HEAD, ST_TAIL: sym_last = (sym_cnt == TAIL_LAST);
         ST_PAYLOAD:       sym_last = (sym_cnt == PAY_LAST);
         ST_GUARD:         sym_last = (sym_cnt == GUARD_LAST);
         default:          sym_last = 1'b0;
      endcase
      if (accept) begin
         state_n    = ST_HEAD;
         sym_cnt_n  = '0;
         bit_n      = 1'b0;
         underrun_n = 1'b0;
`ifdef GMSK_TX_DIFF_ENCODE_EN
         prev_n     = 1'b1;
`endif
      end else if (running) begin
         if (symbol_strobe) begin
            bit_n = (state == ST_PAYLOAD) ? enc_bit : 1'b0;
         end
         if (bit_ready) begin
            if (!bit_valid) begin
               underrun_n = 1'b1;
            end
`ifdef GMSK_TX_DIFF_ENCODE_EN
            prev_n = enc_bit;
`endif
         end
         if (symbol_end) begin
            if (sym_last) begin
               sym_cnt_n = '0;
               state_n   = next_phase(state);
               done_n    = (state == ST_GUARD);
            end else begin
               sym_cnt_n = sym_cnt + 1'b1;
            end
         end
      end
   end

   // State and registered outputs; reset aborts any burst silently.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         sym_cnt    <= '0;
         bit_q      <= 1'b0;
         underrun_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_n;
         sym_cnt    <= sym_cnt_n;
         bit_q      <= bit_n;
         underrun_q <= underrun_n;
         done_q     <= done_n;
      end
   end

`ifdef GMSK_TX_DIFF_ENCODE_EN
   // Previous encoded payload bit for the differential encoder.
   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= prev_n;
      end
   end
`endif

   assign bit_ready         = (state == ST_PAYLOAD) && symbol_strobe;
   assign mod_symbol_strobe = symbol_strobe;
   assign mod_sample_strobe = sample_strobe;
   assign mod_input_bit     = bit_q;
   assign mod_clk_en        = running;
   assign tx_active         = running;
   assign burst_done        = done_q;
   assign underrun          = underrun_q;

endmodule
